// File: rtl/mem_port.sv
// mem_port: word-access sequencer between the multicycle datapath and a
// single-port, variable-latency unified memory. One access per request,
// req/ack handshake, alignment check and a wait-cycle timeout. Read data
// lands in MDR, and also in IR for instruction fetches.
//
// state | meaning
// IDLE  | waiting for start; alignment checked here
// REQ   | mem_req high, waiting for mem_ack or timeout
// DONE  | one-cycle done pulse after a successful access
// ERR   | one-cycle err pulse after misalignment or timeout
module mem_port #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic        fetch,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [31:0] mdr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t         state;
   logic           req_fetch;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_next;

   assign cnt_next = cnt + CW'(1);

   // Outputs are decoded from the registered state only, so neither start
   // nor mem_ack has a combinational path to them.
   assign mem_req = (state == REQ);
   assign done    = (state == DONE);
   assign err     = (state == ERR);
   assign busy    = (state != IDLE);
   assign op      = instr[31:26];
   assign funct   = instr[5:0];

   // Sequencer: request latching, wait counting, IR/MDR capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         req_fetch <= 1'b0;
         cnt       <= '0;
         instr     <= '0;
         mdr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (addr[1:0] == 2'b00) begin
                     mem_we    <= we;
                     mem_addr  <= addr;
                     mem_wdata <= wdata;
                     // A fetch flag on a write is meaningless; drop it here
                     // so the capture logic only has to look at one bit.
                     req_fetch <= fetch & ~we;
                     cnt       <= '0;
                     state     <= REQ;
                  end else begin
                     state <= ERR;
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  if (!mem_we) begin
                     mdr <= mem_rdata;
                     if (req_fetch) instr <= mem_rdata;
                  end
                  state <= DONE;
               end else begin
                  // Counter stops at TIMEOUT because the state leaves REQ.
                  cnt <= cnt_next;
                  if (cnt_next == CW'(TIMEOUT)) state <= ERR;
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
